// File: rtl/cdb_pkg.sv
// Shared constants, types and helpers for the CD block host interface.
package cdb_pkg;

    localparam logic [9:0]  CDB_AA_HI    = 10'h189;

    localparam logic [15:0] REG_HIRQ     = 16'h0008;
    localparam logic [15:0] REG_HIRQMASK = 16'h000C;
    localparam logic [15:0] REG_CR1      = 16'h0018;
    localparam logic [15:0] REG_CR2      = 16'h001C;
    localparam logic [15:0] REG_CR3      = 16'h0020;
    localparam logic [15:0] REG_CR4      = 16'h0024;

    localparam int unsigned HIRQ_CMOK = 0;
    localparam int unsigned HIRQ_SCDQ = 10;

    localparam logic [7:0] CMD_GET_STATUS  = 8'h00;
    localparam logic [7:0] CMD_GET_HW_INFO = 8'h01;

    localparam logic [7:0] STAT_PAUSE    = 8'h20;
    localparam logic [7:0] STAT_PERIODIC = 8'h80;
    localparam logic [7:0] STAT_REJECT   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } cdb_state_e;

    typedef struct packed {
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] r3;
        logic [15:0] r4;
    } cdb_resp_t;

    // Power-on response spells "CDBLOCK".
    localparam cdb_resp_t RESP_RST = '{r1: 16'h0043, r2: 16'h4442, r3: 16'h4C4F, r4: 16'h434B};
    localparam cdb_resp_t RESP_PERIODIC = '{r1: {STAT_PERIODIC | STAT_PAUSE, 8'h00},
                                            r2: 16'h0000, r3: 16'h0000, r4: 16'h0000};

    function automatic logic [15:0] lane_write(input logic [15:0] old_v, input logic [15:0] new_v,
                                               input logic wru_n, input logic wrl_n);
        return {wru_n ? old_v[15:8] : new_v[15:8], wrl_n ? old_v[7:0] : new_v[7:0]};
    endfunction

endpackage

// File: rtl/cdb_cmd_exec.sv
// Combinational command decoder: CMD1 command code -> RESP1..RESP4.
module cdb_cmd_exec
    import cdb_pkg::*;
(
    input  logic [7:0] cmd_code_i,
    output cdb_resp_t  resp_o
);

    always_comb begin
        resp_o = '{r1: {STAT_REJECT, 8'h00}, r2: 16'h0000, r3: 16'h0000, r4: 16'h0000};
        case (cmd_code_i)
            CMD_GET_STATUS:  resp_o = '{r1: {STAT_PAUSE, 8'h00}, r2: 16'h0000, r3: 16'h0000, r4: 16'h0000};
            CMD_GET_HW_INFO: resp_o = '{r1: {STAT_PAUSE, 8'h00}, r2: 16'h0201, r3: 16'h0000, r4: 16'h0400};
            default: ;
        endcase
    end

endmodule

// File: rtl/cdb_host_if.sv
// CD block host register interface on the SCU A-bus (CS2, AA[25:16]=0x189).
// Optional periodic status report enabled by defining CDB_PERIODIC_REPORT_EN.
module cdb_host_if
    import cdb_pkg::*;
#(
    parameter int unsigned CMD_LAT    = 64,
    parameter int unsigned REP_PERIOD = 1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic [25:0] AA,
    input  logic [15:0] ADO,
    output logic [15:0] ADI,
    input  logic        ACS2_N,
    input  logic        ARD_N,
    input  logic        AWRU_N,
    input  logic        AWRL_N,
    output logic        IRQ_N,
    output logic        BUSY
);

    logic             sel;
    logic [15:0]      reg_off;
    logic             wr_en;
    logic             issue;
    logic             complete;
    logic             report;

    cdb_state_e       state_q;
    logic [7:0]       lat_cnt_q;
    logic             busy_q;
    logic             irq_n_q;
    logic [15:0]      hirq_q, hirq_d;
    logic [15:0]      mask_q, mask_d;
    logic [3:0][15:0] cmd_q, cmd_d;
    cdb_resp_t        resp_q, resp_d, exec_resp;
    logic             unused_bits;

    assign sel      = ~ACS2_N && (AA[25:16] == CDB_AA_HI);
    assign reg_off  = {AA[15:1], 1'b0};
    assign wr_en    = sel && !(AWRU_N && AWRL_N);
    assign issue    = wr_en && (reg_off == REG_CR4) && (state_q == ST_IDLE);
    assign complete = (state_q == ST_RESP);

    assign unused_bits = ^{ARD_N, AA[0], cmd_q[0][7:0], cmd_q[3:1]};

    cdb_cmd_exec u_cmd_exec (
        .cmd_code_i (cmd_q[0][15:8]),
        .resp_o     (exec_resp)
    );

`ifdef CDB_PERIODIC_REPORT_EN
    logic [15:0] per_cnt_q;

    assign report = (state_q == ST_IDLE) && (per_cnt_q == 16'(REP_PERIOD - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            per_cnt_q <= '0;
        end else if (CE_R) begin
            if ((state_q != ST_IDLE) || report) per_cnt_q <= '0;
            else                                per_cnt_q <= per_cnt_q + 16'd1;
        end
    end
`else
    localparam int unsigned unused_rep_period = REP_PERIOD;
    assign report = 1'b0;
`endif

    // Internal set events are applied after the host AND-clear so they win a same-cycle collision.
    always_comb begin
        hirq_d = hirq_q;
        mask_d = mask_q;
        cmd_d  = cmd_q;
        resp_d = resp_q;
        if (wr_en) begin
            case (reg_off)
                REG_HIRQ:     hirq_d   = lane_write(hirq_q, hirq_q & ADO, AWRU_N, AWRL_N);
                REG_HIRQMASK: mask_d   = lane_write(mask_q, ADO, AWRU_N, AWRL_N);
                REG_CR1:      cmd_d[0] = lane_write(cmd_q[0], ADO, AWRU_N, AWRL_N);
                REG_CR2:      cmd_d[1] = lane_write(cmd_q[1], ADO, AWRU_N, AWRL_N);
                REG_CR3:      cmd_d[2] = lane_write(cmd_q[2], ADO, AWRU_N, AWRL_N);
                REG_CR4:      cmd_d[3] = lane_write(cmd_q[3], ADO, AWRU_N, AWRL_N);
                default: ;
            endcase
        end
        if (issue) hirq_d[HIRQ_CMOK] = 1'b0;
        if (complete) begin
            resp_d             = exec_resp;
            hirq_d[HIRQ_CMOK]  = 1'b1;
        end
        if (report) begin
            resp_d             = RESP_PERIODIC;
            hirq_d[HIRQ_SCDQ]  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            lat_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else if (CE_R) begin
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        state_q   <= ST_EXEC;
                        lat_cnt_q <= 8'(CMD_LAT - 1);
                        busy_q    <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (lat_cnt_q == '0) state_q <= ST_RESP;
                    else                 lat_cnt_q <= lat_cnt_q - 8'd1;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hirq_q  <= 16'h0001;
            mask_q  <= '1;
            cmd_q   <= '0;
            resp_q  <= RESP_RST;
            irq_n_q <= 1'b1;
        end else if (CE_R) begin
            hirq_q  <= hirq_d;
            mask_q  <= mask_d;
            cmd_q   <= cmd_d;
            resp_q  <= resp_d;
            irq_n_q <= ~|(hirq_q & mask_q);
        end
    end

    always_comb begin
        ADI = '0;
        if (sel) begin
            case (reg_off)
                REG_HIRQ:     ADI = hirq_q;
                REG_HIRQMASK: ADI = mask_q;
                REG_CR1:      ADI = resp_q.r1;
                REG_CR2:      ADI = resp_q.r2;
                REG_CR3:      ADI = resp_q.r3;
                REG_CR4:      ADI = resp_q.r4;
                default: ;
            endcase
        end
    end

    assign IRQ_N = irq_n_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_cdb_host_if.sv
// Self-checking bench for cdb_host_if: directed scenarios plus random bus traffic vs a reference model.
module tb_cdb_host_if;

    localparam int CMD_LAT = 64;
`ifdef CDB_PERIODIC_REPORT_EN
    localparam int REP_PERIOD = 100;
`else
    localparam int REP_PERIOD = 1000;
`endif

    localparam logic [15:0] A_HIRQ = 16'h0008;
    localparam logic [15:0] A_MASK = 16'h000C;
    localparam logic [15:0] A_CR1  = 16'h0018;
    localparam logic [15:0] A_CR2  = 16'h001C;
    localparam logic [15:0] A_CR3  = 16'h0020;
    localparam logic [15:0] A_CR4  = 16'h0024;
    localparam logic [63:0] RESP_AT_RESET = {16'h0043, 16'h4442, 16'h4C4F, 16'h434B};

    logic        CLK = 1'b0;
    logic        RST, CE_R;
    logic [25:0] AA;
    logic [15:0] ADO, ADI;
    logic        ACS2_N, ARD_N, AWRU_N, AWRL_N, IRQ_N, BUSY;

    cdb_host_if #(.CMD_LAT(CMD_LAT), .REP_PERIOD(REP_PERIOD)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .CE_R   (CE_R),
        .AA     (AA),
        .ADO    (ADO),
        .ADI    (ADI),
        .ACS2_N (ACS2_N),
        .ARD_N  (ARD_N),
        .AWRU_N (AWRU_N),
        .AWRL_N (AWRL_N),
        .IRQ_N  (IRQ_N),
        .BUSY   (BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: observable state plus "edges left until the response lands".
    logic [15:0] m_hirq, m_mask, m_cmd1;
    logic [63:0] m_resp;
    logic        m_irq_n;
    int          m_left;
    int          m_idle;

    function automatic logic [15:0] lanes(input logic [15:0] old_v, input logic [15:0] new_v,
                                          input logic u_n, input logic l_n);
        return {u_n ? old_v[15:8] : new_v[15:8], l_n ? old_v[7:0] : new_v[7:0]};
    endfunction

    function automatic logic [63:0] ref_resp(input logic [7:0] code);
        if (code == 8'h00) return {16'h2000, 16'h0000, 16'h0000, 16'h0000};
        if (code == 8'h01) return {16'h2000, 16'h0201, 16'h0000, 16'h0400};
        return {16'hFF00, 48'h0};
    endfunction

    function automatic logic [15:0] ref_read();
        logic [15:0] off;
        off = {AA[15:1], 1'b0};
        if (ACS2_N || AA[25:16] != 10'h189) return 16'h0000;
        case (off)
            A_HIRQ:  return m_hirq;
            A_MASK:  return m_mask;
            A_CR1:   return m_resp[63:48];
            A_CR2:   return m_resp[47:32];
            A_CR3:   return m_resp[31:16];
            A_CR4:   return m_resp[15:0];
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_edge();
        logic [15:0] off, h, cmd1_pre;
        logic        wr, was_busy;
        if (RST) begin
            m_hirq = 16'h0001; m_mask = 16'hFFFF; m_cmd1 = 16'h0000;
            m_resp = RESP_AT_RESET; m_irq_n = 1'b1; m_left = 0; m_idle = 0;
            return;
        end
        if (!CE_R) return;
        off      = {AA[15:1], 1'b0};
        wr       = !ACS2_N && AA[25:16] == 10'h189 && !(AWRU_N && AWRL_N);
        was_busy = (m_left != 0);
        cmd1_pre = m_cmd1;
        m_irq_n  = ~|(m_hirq & m_mask);
        h        = m_hirq;
        if (wr) begin
            if (off == A_HIRQ) h = lanes(h, h & ADO, AWRU_N, AWRL_N);
            if (off == A_MASK) m_mask = lanes(m_mask, ADO, AWRU_N, AWRL_N);
            if (off == A_CR1)  m_cmd1 = lanes(m_cmd1, ADO, AWRU_N, AWRL_N);
        end
        if (was_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_resp = ref_resp(cmd1_pre[15:8]);
                h[0]   = 1'b1;
            end
        end else if (wr && off == A_CR4) begin
            m_left = CMD_LAT + 1;
            h[0]   = 1'b0;
        end
`ifdef CDB_PERIODIC_REPORT_EN
        if (was_busy) m_idle = 0;
        else if (m_idle == REP_PERIOD - 1) begin
            m_idle = 0;
            m_resp = {16'hA000, 48'h0};
            h[10]  = 1'b1;
        end else m_idle++;
`endif
        m_hirq = h;
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_eq("busy", {15'b0, BUSY}, {15'b0, m_left != 0});
        check_eq("irq_n", {15'b0, IRQ_N}, {15'b0, m_irq_n});
        check_eq("adi", ADI, ref_read());
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic bus_idle();
        ACS2_N = 1'b1; ARD_N = 1'b1; AWRU_N = 1'b1; AWRL_N = 1'b1;
        AA = '0; ADO = '0;
    endtask

    task automatic wr(input logic [15:0] off, input logic [15:0] data);
        AA = {10'h189, off}; ACS2_N = 1'b0; ADO = data; AWRU_N = 1'b0; AWRL_N = 1'b0;
        cycle();
        bus_idle();
    endtask

    task automatic rd(input logic [15:0] off, output logic [15:0] v);
        AA = {10'h189, off}; ACS2_N = 1'b0; ARD_N = 1'b0;
        cycle();
        v = ADI;
        bus_idle();
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (BUSY && n < 1000) begin
            cycle();
            n++;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cycle();
        cycle();
        RST = 1'b0;
    endtask

    logic [15:0] offs [7] = '{16'h0008, 16'h000C, 16'h0018, 16'h001C, 16'h0020, 16'h0024, 16'h0000};

    initial begin
        logic [15:0] v, off;
        int          n;

        CE_R = 1'b1;
        bus_idle();
        do_reset();

        // Reset values
        check_eq("rst_irq_n", {15'b0, IRQ_N}, 16'h0001);
        check_eq("rst_busy", {15'b0, BUSY}, 16'h0000);
        rd(A_CR1, v);  check_eq("rst_cr1", v, 16'h0043);
        rd(A_CR2, v);  check_eq("rst_cr2", v, 16'h4442);
        rd(A_CR3, v);  check_eq("rst_cr3", v, 16'h4C4F);
        rd(A_CR4, v);  check_eq("rst_cr4", v, 16'h434B);
        rd(A_HIRQ, v); check_eq("rst_hirq", v, 16'h0001);
        rd(A_MASK, v); check_eq("rst_mask", v, 16'hFFFF);

        // Get HW Info: EXEC lasts CMD_LAT cycles, RESP one more
        wr(A_HIRQ, 16'hFFFE);
        wr(A_CR1, 16'h0100);
        wr(A_CR4, 16'h0000);
        wait_idle(n);
        check_eq("hwinfo_busy_len", 16'(n), 16'(CMD_LAT + 1));
        rd(A_HIRQ, v); check_eq("hwinfo_hirq", v, 16'h0001);
        rd(A_CR1, v);  check_eq("hwinfo_cr1", v, 16'h2000);
        rd(A_CR2, v);  check_eq("hwinfo_cr2", v, 16'h0201);
        rd(A_CR4, v);  check_eq("hwinfo_cr4", v, 16'h0400);

        // Unknown command is rejected
        wr(A_CR1, 16'h7700);
        wr(A_CR4, 16'h0000);
        wait_idle(n);
        rd(A_CR1, v);  check_eq("reject_cr1", v, 16'hFF00);
        rd(A_CR2, v);  check_eq("reject_cr2", v, 16'h0000);

        // Interrupt masking and registered IRQ_N
        wr(A_MASK, 16'h0001);
        cycle();
        check_eq("irq_assert", {15'b0, IRQ_N}, 16'h0000);
        wr(A_HIRQ, 16'h0000);
        check_eq("irq_hold", {15'b0, IRQ_N}, 16'h0000);
        cycle();
        check_eq("irq_release", {15'b0, IRQ_N}, 16'h0001);

        // Host clear landing on the response edge loses to the internal set
        wr(A_CR4, 16'h0000);
        idle(CMD_LAT);
        wr(A_HIRQ, 16'h0000);
        rd(A_HIRQ, v); check_eq("set_priority", v, 16'h0001);

        // CR4 rewrite while busy does not restart the command
        wr(A_CR4, 16'h0000);
        idle(9);
        wr(A_CR4, 16'h0000);
        wait_idle(n);
        check_eq("reissue_ignored", 16'(n), 16'(CMD_LAT - 9));

        // CE_R low freezes the latency counter
        wr(A_CR4, 16'h0000);
        CE_R = 1'b0;
        idle(20);
        CE_R = 1'b1;
        wait_idle(n);
        check_eq("ce_freeze", 16'(n), 16'(CMD_LAT + 1));

        // Reset in EXEC aborts the command
        wr(A_CR1, 16'h0100);
        wr(A_HIRQ, 16'h0000);
        wr(A_CR4, 16'h0000);
        idle(9);
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        check_eq("abort_busy", {15'b0, BUSY}, 16'h0000);
        rd(A_HIRQ, v); check_eq("abort_hirq", v, 16'h0001);
        idle(CMD_LAT + 5);
        rd(A_CR1, v);  check_eq("abort_cr1", v, 16'h0043);
        rd(A_CR2, v);  check_eq("abort_cr2", v, 16'h4442);

        // Periodic status report
        do_reset();
`ifdef CDB_PERIODIC_REPORT_EN
        idle(REP_PERIOD - 1);
        rd(A_CR1, v);  check_eq("periodic_cr1", v, 16'hA000);
        rd(A_HIRQ, v); check_eq("periodic_scdq", v & 16'h0400, 16'h0400);
`else
        idle(REP_PERIOD + 100);
        rd(A_HIRQ, v); check_eq("no_periodic_scdq", v & 16'h0400, 16'h0000);
        rd(A_CR1, v);  check_eq("no_periodic_cr1", v, 16'h0043);
`endif

        // Random bus traffic against the model
        for (int i = 0; i < 4000; i++) begin
            RST    = ($urandom_range(799) == 0);
            CE_R   = ($urandom_range(9) != 0);
            ACS2_N = ($urandom_range(9) == 0);
            off    = offs[$urandom_range(6)];
            if (off == 16'h0000) off = 16'($urandom);
            AA     = {($urandom_range(7) == 0) ? 10'($urandom) : 10'h189, off};
            ADO    = 16'($urandom);
            if (off == A_CR1) ADO[15:8] = ($urandom_range(2) == 0) ? 8'($urandom) : 8'($urandom_range(1));
            AWRU_N = ($urandom_range(3) != 0);
            AWRL_N = ($urandom_range(3) != 0);
            ARD_N  = 1'($urandom);
            cycle();
        end
        RST = 1'b0;
        CE_R = 1'b1;
        bus_idle();
        idle(CMD_LAT + 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
